// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone cycle-type, burst-type and controller state definitions
`timescale 1ns/1ps
package wb_pkg;
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SINGLE,
      ST_BURST,
      ST_ERRS
   } wb_sram_state_e;
endpackage

// File: rtl/wb_if.sv
// rtl/wb_if.sv - Wishbone B4 bus bundle with master and slave views
`timescale 1ns/1ps
interface wb_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   adr;
   logic [2:0]              cti;
   logic [1:0]              bte;
   logic [DATA_WIDTH-1:0]   dat_w;
   logic [DATA_WIDTH-1:0]   dat_r;
   logic [DATA_WIDTH/8-1:0] sel;
   logic                    we;
   logic                    cyc;
   logic                    stb;
   logic                    ack;
   logic                    err;

   modport master (output adr, cti, bte, dat_w, sel, we, cyc, stb, input dat_r, ack, err);
   modport slave  (input adr, cti, bte, dat_w, sel, we, cyc, stb, output dat_r, ack, err);
endinterface

// File: rtl/wb_burst_addr_gen.sv
// rtl/wb_burst_addr_gen.sv - next burst word address for linear and wrapping bursts
`timescale 1ns/1ps
module wb_burst_addr_gen
   import wb_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = 10
) (
   input  logic [MEM_ADDR_WIDTH-1:0] addr_i,
   input  logic [1:0]                bte_i,
   output logic [MEM_ADDR_WIDTH-1:0] next_o,
   output logic                      ovf_o
);
   logic [MEM_ADDR_WIDTH-1:0] mask;
   logic [MEM_ADDR_WIDTH-1:0] incr;

   assign incr = addr_i + MEM_ADDR_WIDTH'(1);

   always_comb begin
      case (bte_i)
         BTE_WRAP4:  mask = MEM_ADDR_WIDTH'(3);
         BTE_WRAP8:  mask = MEM_ADDR_WIDTH'(7);
         BTE_WRAP16: mask = MEM_ADDR_WIDTH'(15);
         default:    mask = '1;
      endcase
   end

   assign next_o = (addr_i & ~mask) | (incr & mask);
   // Only a linear step can leave the window; wrapping bursts stay inside their block.
   assign ovf_o  = (bte_i == BTE_LINEAR) && (&addr_i);
endmodule

// File: rtl/wb_sram_ctrl.sv
// rtl/wb_sram_ctrl.sv - Wishbone B4 slave bridging to a one-cycle-latency synchronous SRAM
`timescale 1ns/1ps
module wb_sram_ctrl
   import wb_pkg::*;
#(
   parameter int                       WB_ADDR_WIDTH  = 32,
   parameter int                       WB_DATA_WIDTH  = 32,
   parameter int                       MEM_ADDR_WIDTH = 10,
   parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   wb_if.slave                        s,
   output logic                       mem_en,
   output logic [WB_DATA_WIDTH/8-1:0] mem_we,
   output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
   output logic [WB_DATA_WIDTH-1:0]   mem_wdata,
   input  logic [WB_DATA_WIDTH-1:0]   mem_rdata
);
   localparam int OFFB = $clog2(WB_DATA_WIDTH/8);
   localparam int AW1  = WB_ADDR_WIDTH + 1;
   localparam logic [WB_ADDR_WIDTH:0] WIN_BYTES = AW1'(1) << (MEM_ADDR_WIDTH + OFFB);

   wb_sram_state_e            state_q, state_d;
   logic [MEM_ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                      we_q, we_d;
   logic                      ovf_q, ovf_d;

   logic [WB_ADDR_WIDTH-1:0]  rel;
   logic [MEM_ADDR_WIDTH-1:0] word;
   logic                      hit;
   logic [MEM_ADDR_WIDTH-1:0] nxt_addr;
   logic                      nxt_ovf;
   logic                      more;
   logic                      ack;
   logic                      err;

   assign rel  = s.adr - BASE_ADDR;
   assign word = rel[OFFB +: MEM_ADDR_WIDTH];
   assign hit  = (s.adr >= BASE_ADDR) && ({1'b0, rel} < WIN_BYTES);
   assign more = (s.cti == CTI_INCR);

   wb_burst_addr_gen #(.MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)) u_addr_gen (
      .addr_i (cnt_q),
      .bte_i  (s.bte),
      .next_o (nxt_addr),
      .ovf_o  (nxt_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      ovf_d    = ovf_q;
      mem_en   = 1'b0;
      mem_we   = '0;
      mem_addr = '0;
      ack      = 1'b0;
      err      = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_IDLE: begin
               if (s.cyc && s.stb) begin
                  if (!hit) begin
                     state_d = ST_ERRS;
                  end else begin
                     mem_en   = 1'b1;
                     mem_we   = s.we ? s.sel : '0;
                     mem_addr = word;
                     cnt_d    = word;
                     we_d     = s.we;
                     ovf_d    = 1'b0;
                     state_d  = more ? ST_BURST : ST_SINGLE;
                  end
               end
            end
            ST_SINGLE: begin
               ack     = s.cyc;
               state_d = ST_IDLE;
            end
            ST_BURST: begin
               if (!s.cyc) begin
                  state_d = ST_IDLE;
               end else if (ovf_q) begin
                  if (s.stb) begin
                     err     = 1'b1;
                     state_d = ST_IDLE;
                  end
               end else if (s.stb) begin
                  ack   = 1'b1;
                  cnt_d = nxt_addr;
                  ovf_d = nxt_ovf;
                  if (we_q) begin
                     mem_en   = 1'b1;
                     mem_we   = s.sel;
                     mem_addr = cnt_q;
                  end else if (more && !nxt_ovf) begin
                     mem_en   = 1'b1;
                     mem_addr = nxt_addr;
                  end
                  if (!more) state_d = ST_IDLE;
               end else if (!we_q) begin
                  // Wait state: refresh the pending beat so its data is ready when STB returns.
                  mem_en   = 1'b1;
                  mem_addr = cnt_q;
               end
            end
            ST_ERRS: begin
               err     = s.cyc;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign s.ack     = ack;
   assign s.err     = err;
   assign s.dat_r   = (ack && !we_q) ? mem_rdata : '0;
   assign mem_wdata = s.dat_w;
endmodule

// File: tb/tb_wb_sram_ctrl.sv
// tb/tb_wb_sram_ctrl.sv - scoreboard bench for wb_sram_ctrl with reference memory model
`timescale 1ns/1ps
module tb_wb_sram_ctrl;
   import wb_pkg::*;

   typedef struct {
      bit          is_err;
      bit          is_read;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_clr;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [31:0] sram [1024];
   logic [31:0] ref_mem [1024];
   exp_t        exp_q [$];
   int          errors = 0;
   int          checks = 0;

   wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb ();

   wb_sram_ctrl #(
      .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .MEM_ADDR_WIDTH(10), .BASE_ADDR(32'h0)
   ) dut (
      .clk(clk), .rst(rst), .s(wb), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) sram[i] <= '0;
      end else if (mem_en) begin
         if (mem_we == 4'b0) mem_rdata <= sram[mem_addr];
         else for (int b = 0; b < 4; b++)
            if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int next_word(input int a, input logic [1:0] bte);
      int size, base;
      case (bte)
         BTE_WRAP4:  size = 4;
         BTE_WRAP8:  size = 8;
         BTE_WRAP16: size = 16;
         default:    return a + 1;
      endcase
      base = a - (a % size);
      return base + ((a - base + 1) % size);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (wb.ack || wb.err) begin
         chk("ack_err_exclusive", {31'b0, wb.ack & wb.err}, 32'h0);
         if (exp_q.size() == 0) begin
            chk("unexpected_response", 32'h1, 32'h0);
         end else begin
            e = exp_q.pop_front();
            chk("resp_kind_err", {31'b0, wb.err}, {31'b0, e.is_err});
            if (e.is_read && wb.ack) chk("read_data", wb.dat_r, e.data);
         end
      end else begin
         chk("dat_r_zero_without_ack", wb.dat_r, 32'h0);
      end
   end

   task automatic classic(input logic [31:0] adr, input bit we, input logic [3:0] sel,
                          input logic [31:0] dat, input logic [2:0] cti);
      exp_t e;
      int   n;
      bit   hit;
      int   w;
      hit = (adr < 32'h1000);
      w   = int'(adr[11:2]);
      if (!hit) e = '{1'b1, 1'b0, 32'h0};
      else if (we) begin
         for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[w][8*b +: 8] = dat[8*b +: 8];
         e = '{1'b0, 1'b0, 32'h0};
      end else e = '{1'b0, 1'b1, ref_mem[w]};
      exp_q.push_back(e);
      @(posedge clk); #1;
      wb.adr = adr; wb.we = we; wb.sel = sel; wb.dat_w = dat;
      wb.cti = cti; wb.bte = BTE_LINEAR; wb.cyc = 1'b1; wb.stb = 1'b1;
      @(negedge clk);
      chk("req_mem_en", {31'b0, mem_en}, {31'b0, hit});
      if (hit) begin
         chk("req_mem_we", {28'b0, mem_we}, {28'b0, (we ? sel : 4'b0)});
         chk("req_mem_addr", {22'b0, mem_addr}, w);
      end
      n = 1;
      while (!(wb.ack || wb.err) && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("classic_latency", n, 2);
      chk("resp_mem_en", {31'b0, mem_en}, 32'h0);
      @(posedge clk); #1;
      wb.cyc = 1'b0; wb.stb = 1'b0;
   endtask

   task automatic burst(input int start, input int n, input bit we, input logic [1:0] bte,
                        input int gap_after, input int gap_len);
      int          a, n_eff, k, cnt, gap_left, exp_cyc;
      int          adrs [$];
      logic [31:0] wd [$];
      logic [31:0] d;
      bit          got;
      a = start;
      n_eff = n;
      for (int i = 0; i < n; i++) begin
         if (a >= 1024) begin
            exp_q.push_back('{1'b1, 1'b0, 32'h0});
            adrs.push_back(a); wd.push_back(32'h0);
            n_eff = i + 1;
            break;
         end
         d = $urandom;
         adrs.push_back(a); wd.push_back(d);
         if (we) begin
            ref_mem[a] = d;
            exp_q.push_back('{1'b0, 1'b0, 32'h0});
         end else exp_q.push_back('{1'b0, 1'b1, ref_mem[a]});
         a = next_word(a, bte);
      end
      @(posedge clk); #1;
      wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we; wb.sel = 4'hF; wb.bte = bte;
      wb.adr = 32'(adrs[0]) << 2; wb.dat_w = wd[0]; wb.cti = (n == 1) ? CTI_EOB : CTI_INCR;
      k = 0; cnt = 0; gap_left = 0;
      while (k < n_eff && cnt < 200) begin
         @(negedge clk);
         cnt++;
         got = wb.ack | wb.err;
         if (!wb.stb) chk("no_ack_in_gap", {31'b0, got}, 32'h0);
         @(posedge clk); #1;
         if (got) begin
            k++;
            if (k == gap_after && k < n_eff) begin
               wb.stb = 1'b0;
               gap_left = gap_len;
            end
         end else if (!wb.stb) begin
            gap_left--;
            if (gap_left <= 0) wb.stb = 1'b1;
         end
         if (k < n_eff) begin
            wb.adr = 32'(adrs[k]) << 2; wb.dat_w = wd[k];
            wb.cti = (k == n - 1) ? CTI_EOB : CTI_INCR;
         end else begin
            wb.cyc = 1'b0; wb.stb = 1'b0; wb.cti = CTI_CLASSIC;
         end
      end
      exp_cyc = n_eff + 1 + ((gap_after > 0 && gap_after < n_eff) ? gap_len : 0);
      chk("burst_beats", k, n_eff);
      chk("burst_cycles", cnt, exp_cyc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks, cnt, op;
      rst = 1'b1; mem_clr = 1'b1;
      wb.adr = '0; wb.cti = '0; wb.bte = '0; wb.dat_w = '0; wb.sel = '0;
      wb.we = 1'b0; wb.cyc = 1'b0; wb.stb = 1'b0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      repeat (3) @(posedge clk);
      #1; rst = 1'b0; mem_clr = 1'b0;
      @(negedge clk);
      chk("rst_ack", {31'b0, wb.ack}, 32'h0);
      chk("rst_err", {31'b0, wb.err}, 32'h0);
      chk("rst_dat_r", wb.dat_r, 32'h0);
      chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
      chk("rst_mem_we", {28'b0, mem_we}, 32'h0);
      chk("rst_mem_addr", {22'b0, mem_addr}, 32'h0);

      classic(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, CTI_CLASSIC);
      classic(32'h10, 1'b0, 4'hF, 32'h0, CTI_CLASSIC);
      classic(32'h10, 1'b1, 4'b0010, 32'h0000AB00, CTI_CLASSIC);
      classic(32'h10, 1'b0, 4'hF, 32'h0, CTI_CONST);
      chk("byte_merge_model", ref_mem[4], 32'hDEADABEF);
      for (int i = 0; i < 4; i++) classic(32'h20 + 32'(4 * i), 1'b1, 4'hF, 32'(i + 1), CTI_CLASSIC);
      burst(8, 4, 1'b0, BTE_LINEAR, 0, 0);
      burst(10, 4, 1'b0, BTE_WRAP4, 0, 0);
      burst(8, 4, 1'b0, BTE_LINEAR, 2, 2);
      classic(32'h1000, 1'b0, 4'hF, 32'h0, CTI_CLASSIC);
      burst(1022, 4, 1'b0, BTE_LINEAR, 0, 0);
      burst(1021, 4, 1'b1, BTE_LINEAR, 0, 0);

      exp_q.push_back('{1'b0, 1'b1, ref_mem[8]});
      exp_q.push_back('{1'b0, 1'b1, ref_mem[9]});
      @(posedge clk); #1;
      wb.adr = 32'h20; wb.we = 1'b0; wb.sel = 4'hF; wb.bte = BTE_LINEAR;
      wb.cti = CTI_INCR; wb.cyc = 1'b1; wb.stb = 1'b1;
      acks = 0; cnt = 0;
      while (acks < 2 && cnt < 20) begin
         @(negedge clk);
         cnt++;
         if (wb.ack) acks++;
      end
      chk("rst_burst_acks", acks, 2);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("in_rst_ack", {31'b0, wb.ack}, 32'h0);
      chk("in_rst_mem_en", {31'b0, mem_en}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; wb.cyc = 1'b0; wb.stb = 1'b0; wb.cti = CTI_CLASSIC;
      @(negedge clk);
      chk("post_rst_ack", {31'b0, wb.ack}, 32'h0);
      chk("post_rst_mem_en", {31'b0, mem_en}, 32'h0);
      classic(32'h10, 1'b0, 4'hF, 32'h0, CTI_CLASSIC);

      for (int it = 0; it < 40; it++) begin
         op = $urandom_range(0, 2);
         if (op < 2) begin
            classic($urandom_range(0, 32'h13FF) & ~32'h3, $urandom_range(0, 1) == 1,
                    4'($urandom_range(1, 15)), $urandom,
                    ($urandom_range(0, 1) == 1) ? CTI_CONST : CTI_CLASSIC);
         end else begin
            int st, n, ga;
            st = ($urandom_range(0, 3) == 0) ? $urandom_range(1016, 1023) : $urandom_range(0, 1023);
            n  = $urandom_range(2, 8);
            ga = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : 0;
            burst(st, n, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), ga, $urandom_range(1, 3));
         end
      end

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
